// File: rtl/ram_stream_reader_if.sv
// Command, RAM read-port and output-stream bundle
// shared by ram_stream_reader and its environment.
interface ram_stream_reader_if #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 12
);
  logic                  cfg_start;
  logic [ADDR_WIDTH-1:0] cfg_base_addr;
  logic [ADDR_WIDTH:0]   cfg_num_words;
  logic [ADDR_WIDTH-1:0] cfg_stride;
  logic                  busy;
  logic                  done;
  logic                  mem_read_req;
  logic [ADDR_WIDTH-1:0] mem_read_addr;
  logic [DATA_WIDTH-1:0] mem_read_data;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    input  cfg_start, cfg_base_addr,
    input  cfg_num_words, cfg_stride,
    input  mem_read_data, m_ready,
    output busy, done,
    output mem_read_req, mem_read_addr,
    output m_data, m_valid, m_last
  );

  modport slave (
    output cfg_start, cfg_base_addr,
    output cfg_num_words, cfg_stride,
    output mem_read_data, m_ready,
    input  busy, done,
    input  mem_read_req, mem_read_addr,
    input  m_data, m_valid, m_last
  );
endinterface

// File: rtl/ram_stream_reader.sv
// Strided scratchpad read engine feeding a valid/ready
// stream through a credit-checked skid FIFO.
module ram_stream_reader #(
  parameter int DATA_WIDTH   = 10,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = READ_LATENCY + 2
) (
  input logic                 clk,
  input logic                 reset,
  ram_stream_reader_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = ADDR_WIDTH + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [NW-1:0]         num_q, num_d;
  logic [NW-1:0]         issue_q, issue_d;
  logic [NW-1:0]         pop_q, pop_d;
  logic                  zero_q, zero_d;
  logic                  infl_q;

  logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic        issue, push, pop, valid, is_last;
  logic [CW:0] credit;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST_P) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    num_d    = num_q;
    issue_d  = issue_q;
    pop_d    = pop_q;
    zero_d   = zero_q;
    issue    = 1'b0;
    // in-flight reads already own a FIFO slot
    credit  = {1'b0, cnt_q} + {{CW{1'b0}}, infl_q};
    valid   = (cnt_q != '0);
    pop     = valid & bus.m_ready;
    is_last = valid & (pop_q == num_q - NW'(1));
    if (pop) pop_d = pop_q + NW'(1);
    unique case (state_q)
      S_IDLE: begin
        if (bus.cfg_start) begin
          addr_d   = bus.cfg_base_addr;
          stride_d = bus.cfg_stride;
          num_d    = bus.cfg_num_words;
          issue_d  = '0;
          pop_d    = '0;
          zero_d   = (bus.cfg_num_words == '0);
          state_d  = zero_d ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if ((issue_q < num_q) &&
            (credit < DEPTH_C)) begin
          issue   = 1'b1;
          addr_d  = addr_q + stride_q;
          issue_d = issue_q + NW'(1);
          if (issue_d == num_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop & is_last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    push  = (READ_LATENCY == 0) ? issue : infl_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      num_q    <= '0;
      issue_q  <= '0;
      pop_q    <= '0;
      zero_q   <= 1'b0;
      infl_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      num_q    <= num_d;
      issue_q  <= issue_d;
      pop_q    <= pop_d;
      zero_q   <= zero_d;
      infl_q   <= (READ_LATENCY == 1) ? issue : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        fifo_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= bus.mem_read_data;
        wptr_q <= nxt(wptr_q);
      end
      if (pop) rptr_q <= nxt(rptr_q);
      cnt_q <= cnt_d;
    end
  end

  assign bus.busy = (state_q == S_RUN) |
                    (state_q == S_DRAIN) |
                    ((state_q == S_DONE) & zero_q);
  assign bus.done          = (state_q == S_DONE);
  assign bus.mem_read_req  = issue;
  assign bus.mem_read_addr = addr_q;
  assign bus.m_valid       = valid;
  assign bus.m_data        = fifo_q[rptr_q];
  assign bus.m_last        = is_last;
endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: latency-1 and
// latency-0 builds, scoreboarded addresses and beats.
module tb_ram_stream_reader;
  localparam int DW = 10;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start;
  logic [AW-1:0] base, stride;
  logic [AW:0]   num;
  logic          rdy;
  logic          sel0;

  ram_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();
  ram_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();

  assign if1.cfg_start     = start;
  assign if1.cfg_base_addr = base;
  assign if1.cfg_num_words = num;
  assign if1.cfg_stride    = stride;
  assign if1.m_ready       = rdy;
  assign if0.cfg_start     = start;
  assign if0.cfg_base_addr = base;
  assign if0.cfg_num_words = num;
  assign if0.cfg_stride    = stride;
  assign if0.m_ready       = rdy;

  ram_stream_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)
  ) u_dut1 (.clk(clk), .reset(rst), .bus(if1));

  ram_stream_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(0)
  ) u_dut0 (.clk(clk), .reset(rst), .bus(if0));

  logic [DW-1:0] mem [1 << AW];
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);

  always @(posedge clk)
    if (if1.mem_read_req) if1.mem_read_data <= mem[if1.mem_read_addr];
  assign if0.mem_read_data = mem[if0.mem_read_addr];

  logic          mv, mr, ml, mreq, mdone, mbusy;
  logic [DW-1:0] md;
  logic [AW-1:0] maddr;
  int            depth;
  assign mv    = sel0 ? if0.m_valid : if1.m_valid;
  assign mr    = rdy;
  assign ml    = sel0 ? if0.m_last : if1.m_last;
  assign md    = sel0 ? if0.m_data : if1.m_data;
  assign mreq  = sel0 ? if0.mem_read_req : if1.mem_read_req;
  assign maddr = sel0 ? if0.mem_read_addr : if1.mem_read_addr;
  assign mdone = sel0 ? if0.done : if1.done;
  assign mbusy = sel0 ? if0.busy : if1.busy;
  assign depth = sel0 ? 2 : 3;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] addr_q [$];
  logic [DW:0]   beat_q [$];
  logic [AW-1:0] ea;
  logic [DW:0]   eb;
  int            outst, start_cyc;
  int            first_req, first_val, last_hs;
  int            done_cyc, done_cnt, busy_cnt;
  logic          stall_p, mon_en;
  logic [DW-1:0] d_p;

  always @(negedge clk) begin
    if (mon_en) begin
      if (mreq) begin
        n_cmp++;
        assert (addr_q.size() != 0) else begin
          n_err++;
          $error("FAIL unexp_req: got addr %0h want no request", maddr);
        end
        if (addr_q.size() != 0) begin
          ea = addr_q.pop_front();
          n_cmp++;
          assert (maddr === ea) else begin
            n_err++;
            $error("FAIL rd_addr: got %0h want %0h", maddr, ea);
          end
        end
        n_cmp++;
        assert (outst < depth) else begin
          n_err++;
          $error("FAIL credit: got outstanding %0d want < %0d", outst, depth);
        end
        if (first_req < 0) first_req = cyc;
      end
      if (stall_p) begin
        n_cmp++;
        assert (mv === 1'b1 && md === d_p) else begin
          n_err++;
          $error("FAIL hold: got v=%0b d=%0h want v=1 d=%0h", mv, md, d_p);
        end
      end
      if (mv && first_val < 0) first_val = cyc;
      if (mv && mr) begin
        n_cmp++;
        assert (beat_q.size() != 0) else begin
          n_err++;
          $error("FAIL unexp_beat: got %0h want no beat", md);
        end
        if (beat_q.size() != 0) begin
          eb = beat_q.pop_front();
          n_cmp++;
          assert ({ml, md} === eb) else begin
            n_err++;
            $error("FAIL beat: got last=%0b d=%0h want last=%0b d=%0h",
                   ml, md, eb[DW], eb[DW-1:0]);
          end
        end
        last_hs = cyc;
      end
      if (mdone) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (mbusy) busy_cnt++;
      outst   = outst + (mreq ? 1 : 0) - ((mv && mr) ? 1 : 0);
      stall_p = mv && !mr;
      d_p     = md;
    end
  end

  task automatic clear();
    addr_q.delete();
    beat_q.delete();
    outst     = 0;
    stall_p   = 1'b0;
    first_req = -1;
    first_val = -1;
    last_hs   = -1;
    done_cyc  = -1;
    done_cnt  = 0;
    busy_cnt  = 0;
  endtask

  task automatic cmd(input logic [AW-1:0] b,
                     input logic [AW:0] n,
                     input logic [AW-1:0] s);
    logic [AW-1:0] a;
    a = b;
    for (int i = 0; i < int'(n); i++) begin
      addr_q.push_back(a);
      beat_q.push_back({(i == int'(n) - 1), a[DW-1:0]});
      a = a + s;
    end
    start = 1'b1;
    base = b;
    num = n;
    stride = s;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic settle();
    for (int k = 0; k < 60; k++) begin
      if (!if0.busy && !if1.busy && !if0.done && !if1.done) break;
      rdy = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic run(input int maxc, input bit rnd);
    for (int i = 0; i < maxc && done_cnt == 0; i++) begin
      if (!rnd) rdy = 1'b1;
      else if (i >= 12 && i < 22) rdy = 1'b0;
      else rdy = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    assert (done_cnt == 1) else begin
      n_err++;
      $error("FAIL done_count: got %0d want 1", done_cnt);
    end
    n_cmp++;
    assert (addr_q.size() == 0 && beat_q.size() == 0) else begin
      n_err++;
      $error("FAIL drained: got %0d addr %0d beats left want 0 0",
             addr_q.size(), beat_q.size());
    end
    settle();
  endtask

  task automatic chk_reset();
    n_cmp++;
    assert ({mbusy, mdone, mreq, mv, ml} === 5'b0) else begin
      n_err++;
      $error("FAIL rst_ctrl: got %b want 00000", {mbusy, mdone, mreq, mv, ml});
    end
    n_cmp++;
    assert (maddr === '0 && md === '0) else begin
      n_err++;
      $error("FAIL rst_data: got addr %0h data %0h want 0 0", maddr, md);
    end
  endtask

  task automatic chk(input string tag, input int got, input int want);
    n_cmp++;
    assert (got == want) else begin
      n_err++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base = '0;
    num = '0;
    stride = '0;
    rdy = 1'b0;
    sel0 = 1'b0;
    mon_en = 1'b0;
    clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // basic burst, latency and throughput
    clear();
    cmd(12'h010, 13'd8, 12'd1);
    run(100, 1'b0);
    chk("t1_req_lat", first_req - start_cyc, 1);
    chk("t1_val_lat", first_val - first_req, 2);
    chk("t1_burst", last_hs - first_val, 7);
    chk("t1_done", done_cyc - last_hs, 1);

    // address wrap
    clear();
    cmd(12'hFFE, 13'd4, 12'd1);
    run(100, 1'b0);
    chk("t2_burst", last_hs - first_val, 3);

    // stride with random and long back-pressure
    clear();
    cmd(12'h000, 13'd16, 12'd3);
    run(400, 1'b1);

    // empty command, start while busy ignored
    clear();
    cmd(12'h200, 13'd0, 12'd1);
    start = 1'b1;
    base = 12'h300;
    num = 13'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_done_lat", done_cyc - start_cyc, 1);
    chk("t4_busy_cnt", busy_cnt, 1);
    chk("t4_no_req", first_req, -1);
    chk("t4_no_val", first_val, -1);

    // reset with reads queued
    clear();
    rdy = 1'b0;
    cmd(12'h000, 13'd20, 12'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("t5_queued", outst, 3);
    rst = 1'b1;
    mon_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    clear();
    @(negedge clk);
    chk_reset();
    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t5_no_done", done_cnt, 0);
    cmd(12'h100, 13'd2, 12'd1);
    run(100, 1'b0);

    // combinational-read build
    sel0 = 1'b1;
    clear();
    cmd(12'h020, 13'd5, 12'd2);
    run(100, 1'b0);
    chk("t6_req_lat", first_req - start_cyc, 1);
    chk("t6_val_lat", first_val - first_req, 1);
    chk("t6_burst", last_hs - first_val, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Downstream read engine for the on-chip scratchpad RAM.
- Takes a one-shot command (base, word count, stride) and issues read requests to the RAM's read port. Handles the RAM's 0- or 1-cycle read latency.
- Delivers the words in order on a valid/ready stream to the next compute stage.
- Keeps reads decoupled from consumer back-pressure with a small internal skid FIFO; sustains one word per cycle when the consumer never stalls.

Parameters:
- DATA_WIDTH, 10, width of RAM words and of the output stream.
- ADDR_WIDTH, 12, RAM address width; the address space is 2^ADDR_WIDTH words.
- READ_LATENCY, 1, RAM read latency in cycles. Legal values: 0 (combinational read) or 1 (registered read, data valid the cycle after the request).
- FIFO_DEPTH, READ_LATENCY+2, skid FIFO entries; minimum READ_LATENCY+2.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  reset, synchronous, active-high.
- cfg_start  input  1  one-cycle command strobe; accepted only when busy=0.
- cfg_base_addr  input  ADDR_WIDTH  first word address.
- cfg_num_words  input  ADDR_WIDTH+1  number of words to read, 0..2^ADDR_WIDTH.
- cfg_stride  input  ADDR_WIDTH  address increment per word; 0 is legal and repeats the same address.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse at command completion.
- mem_read_req  output  1  RAM read request.
- mem_read_addr  output  ADDR_WIDTH  RAM read address.
- mem_read_data  input  DATA_WIDTH  RAM read data.
- m_data  output  DATA_WIDTH  stream data.
- m_valid  output  1  stream valid.
- m_ready  input  1  stream ready from the consumer.
- m_last  output  1  marks the final word of a command; qualified by m_valid.

Behaviour:
- Reset values: busy=0, done=0, mem_read_req=0, mem_read_addr=0, m_valid=0, m_last=0, m_data=0. The FIFO, in-flight counter and all counters are cleared.
- Reset mid-command aborts the command: no done pulse, FIFO contents discarded, in-flight returns ignored.
- FSM IDLE -> RUN:
  - Taken on cfg_start with cfg_num_words != 0.
  - cfg_base_addr, cfg_num_words and cfg_stride are latched. cfg_* inputs are ignored after the start cycle.
- FSM IDLE -> DONE:
  - Taken on cfg_start with cfg_num_words == 0.
  - No reads, no stream beats. done pulses in the cycle after start; busy is high only in that same cycle.
- RUN state:
  - A read is issued (mem_read_req=1) when issue_count < num_words and fifo_occupancy + inflight < FIFO_DEPTH. This credit check guarantees the FIFO never overflows.
  - mem_read_addr = base + issue_index*stride, modulo 2^ADDR_WIDTH (wrap-around, no error).
  - The address register advances by stride on each issue.
  - READ_LATENCY=1: mem_read_data is captured into the FIFO the cycle after the request.
  - READ_LATENCY=0: mem_read_data is captured in the request cycle.
- RUN -> DRAIN: when issue_count reaches num_words. DRAIN issues no reads.
- DRAIN -> DONE: on the handshake (m_valid & m_ready) of the word with m_last.
- DONE -> IDLE: after one cycle. done=1 for exactly that cycle; busy drops in the same cycle that done rises.
- m_last: asserted with the num_words-th beat only.
- Stream rules:
  - m_valid and m_data come from the FIFO head and are driven from registers.
  - Once asserted, m_valid stays high and m_data stays stable until the handshake.
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
- Throughput: with m_ready held high, one beat per cycle after an initial latency of READ_LATENCY+1 cycles from the first request.
- Back-pressure: with m_ready low, issue stops once occupancy + inflight = FIFO_DEPTH. No data is ever lost or duplicated.
- cfg_start while busy: ignored; no state change.
- Counters are ADDR_WIDTH+1 bits so num_words = 2^ADDR_WIDTH completes correctly.

Test Plan:
- Test 1:
  - Setup: RAM preloaded mem[i]=i, READ_LATENCY=1, m_ready=1; start base=0x010, num=8, stride=1.
  - Expected: beats 0x010..0x017 on 8 consecutive cycles; m_last on 0x017; done one cycle after the last handshake.
- Test 2:
  - Setup: wrap-around; start base=0xFFE, num=4, stride=1.
  - Expected: addresses 0xFFE, 0xFFF, 0x000, 0x001; data in that order.
- Test 3:
  - Setup: base=0, num=16, stride=3; m_ready toggled pseudo-randomly, plus a run of 10 cycles low.
  - Expected: data 0,3,…,45 in order; no drops or duplicates; mem_read_req never raises occupancy + inflight above FIFO_DEPTH; m_data stable while m_valid & !m_ready.
- Test 4:
  - Setup: num=0.
  - Expected: no mem_read_req, no m_valid; done pulse the cycle after start. A second cfg_start asserted while busy is ignored.
- Test 5:
  - Setup: reset asserted for one cycle with 3 words in flight / queued during a num=20 command.
  - Expected: the next cycle shows all outputs at reset values; no done pulse. A new command (base=0x100, num=2) then returns 0x100, 0x101 correctly.
- Test 6:
  - Setup: READ_LATENCY=0 build; base=0x020, num=5, stride=2, m_ready=1.
  - Expected: beats 0x020, 0x022, 0x024, 0x026, 0x028 back-to-back; first m_valid one cycle after the first request.
